store_buffer: RTL and testbench

Posted-write buffer between the single-cycle ARM core's data-memory write port (MemWrite/DataAdr/WriteData) and a data memory that accepts writes through a valid/ready handshake. Captures core stores into a small FIFO so the core continues without waiting on memory. Drains stores in program order. Forwards the youngest buffered store data to core loads that hit a pending address.

---
 rtl/store_buffer_pkg.sv | 24 ++
 rtl/store_buffer_fifo.sv | 51 +++++
 rtl/store_buffer.sv | 100 ++++++++++
 tb/tb_store_buffer.sv | 351 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/store_buffer_pkg.sv
// Shared types for the posted-write store buffer: entry layout, FSM states and
// the word-address compare used by load forwarding.
package store_buffer_pkg;

  localparam int SB_AW = 32;
  localparam int SB_DW = 32;

  typedef struct packed {
    logic [SB_AW-1:0] addr;
    logic [SB_DW-1:0] data;
  } sb_entry_t;

  typedef enum logic {
    RUN   = 1'b0,
    FENCE = 1'b1
  } sb_state_t;

  // Byte offset bits are masked so any byte within a word counts as a hit.
  function automatic logic word_match(input logic [SB_AW-1:0] a,
                                      input logic [SB_AW-1:0] b);
    return ((a ^ b) & ~SB_AW'(3)) == '0;
  endfunction

endpackage

// File: rtl/store_buffer_fifo.sv
// Circular store queue: entry storage, read/write pointers and a separate
// occupancy counter. The whole entry array is exported for forwarding.
module store_buffer_fifo
  import store_buffer_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int PW    = $clog2(DEPTH),
  parameter int CW    = PW + 1
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          push,
  input  logic          pop,
  input  sb_entry_t     push_entry,
  output sb_entry_t     head,
  output sb_entry_t     entries [DEPTH],
  output logic [PW-1:0] rd_ptr,
  output logic [CW-1:0] count,
  output logic          full,
  output logic          empty
);

  sb_entry_t     mem [DEPTH];
  logic [PW-1:0] wr_ptr;

  // Storage is deliberately left out of reset; validity comes from count.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= push_entry;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      if (push && !pop && count != CW'(DEPTH))
        count <= count + CW'(1);
      else if (!push && pop && count != '0)
        count <= count - CW'(1);
    end
  end

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign head    = mem[rd_ptr];
  assign entries = mem;

endmodule

// File: rtl/store_buffer.sv
// Posted-write buffer between the core store port and a valid/ready data
// memory, with program-order drain, fence handling and load forwarding.
//
//   state | meaning
//   RUN   | stores accepted while not full; buffer drains in the background
//   FENCE | stores blocked, core stalled until the buffer has fully drained
module store_buffer
  import store_buffer_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int AW    = SB_AW,
  parameter int DW    = SB_DW,
  parameter int PW    = $clog2(DEPTH),
  parameter int CW    = PW + 1
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          cpu_we,
  input  logic [AW-1:0] cpu_addr,
  input  logic [DW-1:0] cpu_wdata,
  input  logic [AW-1:0] cpu_raddr,
  input  logic          fence,
  output logic          cpu_stall,
  output logic          fwd_hit,
  output logic [DW-1:0] fwd_data,
  output logic          mem_valid,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic          mem_ready,
  output logic [CW-1:0] count,
  output logic          empty
);

  sb_state_t     state;
  sb_entry_t     head;
  sb_entry_t     entries [DEPTH];
  sb_entry_t     push_entry;
  logic [PW-1:0] rd_ptr;
  logic          full;
  logic          push;
  logic          pop;
  logic          drained;

  assign push_entry = '{addr: cpu_addr, data: cpu_wdata};
  assign push       = cpu_we && !full && (state == RUN);
  assign pop        = mem_valid && mem_ready;

  store_buffer_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk        (clk),
    .reset_n    (reset_n),
    .push       (push),
    .pop        (pop),
    .push_entry (push_entry),
    .head       (head),
    .entries    (entries),
    .rd_ptr     (rd_ptr),
    .count      (count),
    .full       (full),
    .empty      (empty)
  );

  assign mem_valid = !empty;
  assign mem_addr  = head.addr;
  assign mem_wdata = head.data;

  // Leaving FENCE registers on the same edge that retires the last entry.
  assign drained = empty || (count == CW'(1) && pop);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= RUN;
    end else begin
      case (state)
        RUN:     if (fence && !empty) state <= FENCE;
        FENCE:   if (drained) state <= RUN;
        default: state <= RUN;
      endcase
    end
  end

  assign cpu_stall = (cpu_we && full) || (state == FENCE);

  // Walk oldest to youngest so the last match found is the youngest store.
  always_comb begin
    logic [PW-1:0] idx;
    idx      = '0;
    fwd_hit  = 1'b0;
    fwd_data = '0;
    for (int k = 0; k < DEPTH; k++) begin
      idx = rd_ptr + PW'(k);
      if (CW'(k) < count && word_match(entries[idx].addr, cpu_raddr)) begin
        fwd_hit  = 1'b1;
        fwd_data = entries[idx].data;
      end
    end
  end

endmodule

// File: tb/tb_store_buffer.sv
// Self-checking bench for store_buffer: directed scenarios plus randomized
// traffic checked against a queue-based reference model.
module tb_store_buffer;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        cpu_we;
  logic [31:0] cpu_addr;
  logic [31:0] cpu_wdata;
  logic [31:0] cpu_raddr;
  logic        fence;
  logic        cpu_stall;
  logic        fwd_hit;
  logic [31:0] fwd_data;
  logic        mem_valid;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_ready;
  logic [2:0]  count;
  logic        empty;

  int n_checks = 0;
  int n_pass   = 0;

  // reference model: pending stores in program order, plus the fence flag
  logic [31:0] mq_a[$];
  logic [31:0] mq_d[$];
  bit          m_fence;

  logic [2:0]  e_count;
  logic        e_empty, e_valid, e_stall, e_hit;
  logic [31:0] e_fwd, e_ha, e_hd;

  store_buffer #(.DEPTH(DEPTH)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .cpu_we    (cpu_we),
    .cpu_addr  (cpu_addr),
    .cpu_wdata (cpu_wdata),
    .cpu_raddr (cpu_raddr),
    .fence     (fence),
    .cpu_stall (cpu_stall),
    .fwd_hit   (fwd_hit),
    .fwd_data  (fwd_data),
    .mem_valid (mem_valid),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_ready (mem_ready),
    .count     (count),
    .empty     (empty)
  );

  always #5 clk = ~clk;

  function automatic void model_eval();
    int sz;
    sz      = mq_a.size();
    e_count = 3'(sz);
    e_empty = (sz == 0);
    e_valid = (sz != 0);
    e_stall = (cpu_we && sz == DEPTH) || m_fence;
    e_hit   = 1'b0;
    e_fwd   = '0;
    e_ha    = '0;
    e_hd    = '0;
    for (int i = sz - 1; i >= 0; i--) begin
      if (mq_a[i][31:2] == cpu_raddr[31:2]) begin
        e_hit = 1'b1;
        e_fwd = mq_d[i];
        break;
      end
    end
    if (sz != 0) begin
      e_ha = mq_a[0];
      e_hd = mq_d[0];
    end
  endfunction

  // Advance one clock edge and apply the same edge to the model.
  task automatic tick();
    int sz;
    bit pop, acc, nf;
    @(posedge clk);
    if (!reset_n) begin
      mq_a.delete();
      mq_d.delete();
      m_fence = 0;
    end else begin
      sz  = mq_a.size();
      pop = (sz != 0) && mem_ready;
      acc = cpu_we && (sz < DEPTH) && !m_fence;
      if (!m_fence) nf = fence && (sz != 0);
      else          nf = (sz - int'(pop)) != 0;
      if (pop) begin
        void'(mq_a.pop_front());
        void'(mq_d.pop_front());
      end
      if (acc) begin
        mq_a.push_back(cpu_addr);
        mq_d.push_back(cpu_wdata);
      end
      m_fence = nf;
    end
    #1;
  endtask

  task automatic store(input logic [31:0] a, input logic [31:0] d);
    cpu_we    = 1'b1;
    cpu_addr  = a;
    cpu_wdata = d;
    tick();
    cpu_we    = 1'b0;
  endtask

  task automatic test_reset();
    reset_n = 1'b0; cpu_we = 0; cpu_addr = 0; cpu_wdata = 0;
    cpu_raddr = 0; fence = 1'b1; mem_ready = 0;
    m_fence = 0;
    #3;
    n_checks++;
    if ({empty, count, mem_valid} !== {1'b1, 3'd0, 1'b0})
      $display("FAIL reset_occupancy got empty=%b count=%0d valid=%b want 1/0/0", empty, count, mem_valid);
    else n_pass++;
    n_checks++;
    if ({cpu_stall, fwd_hit, fwd_data} !== {1'b0, 1'b0, 32'd0})
      $display("FAIL reset_outputs got stall=%b hit=%b fwd=%h want 0/0/0", cpu_stall, fwd_hit, fwd_data);
    else n_pass++;
    fence = 1'b0;
    @(posedge clk);
    #1 reset_n = 1'b1;
  endtask

  task automatic test_basic_store();
    mem_ready = 1'b1;
    store(32'd100, 32'd7);
    n_checks++;
    if ({mem_valid, mem_addr, mem_wdata} !== {1'b1, 32'd100, 32'd7})
      $display("FAIL basic_head got valid=%b addr=%0d data=%0d want 1/100/7", mem_valid, mem_addr, mem_wdata);
    else n_pass++;
    tick();
    n_checks++;
    if ({empty, mem_valid} !== 2'b10)
      $display("FAIL basic_retire got empty=%b valid=%b want 1/0", empty, mem_valid);
    else n_pass++;
  endtask

  task automatic test_fill_stall();
    mem_ready = 1'b0;
    for (int i = 0; i < 4; i++) store(32'd96 + 32'(4 * i), 32'(i + 1));
    n_checks++;
    if (count !== 3'd4)
      $display("FAIL fill_count got %0d want 4", count);
    else n_pass++;
    cpu_we = 1'b1; cpu_addr = 32'd112; cpu_wdata = 32'd99;
    @(negedge clk);
    n_checks++;
    if (cpu_stall !== 1'b1)
      $display("FAIL full_stall got %b want 1", cpu_stall);
    else n_pass++;
    tick();
    cpu_we = 1'b0;
    n_checks++;
    if (count !== 3'd4)
      $display("FAIL full_no_enqueue got count=%0d want 4", count);
    else n_pass++;
    mem_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      n_checks++;
      if ({mem_valid, mem_addr, mem_wdata} !== {1'b1, 32'd96 + 32'(4 * i), 32'(i + 1)})
        $display("FAIL drain_order[%0d] got valid=%b addr=%0d data=%0d want 1/%0d/%0d",
                 i, mem_valid, mem_addr, mem_wdata, 96 + 4 * i, i + 1);
      else n_pass++;
      tick();
    end
    n_checks++;
    if (empty !== 1'b1)
      $display("FAIL drain_empty got %b want 1", empty);
    else n_pass++;
  endtask

  task automatic test_forwarding();
    mem_ready = 1'b0;
    store(32'd100, 32'd5);
    store(32'd100, 32'd7);
    cpu_raddr = 32'd100;
    @(negedge clk);
    n_checks++;
    if ({fwd_hit, fwd_data} !== {1'b1, 32'd7})
      $display("FAIL fwd_youngest got hit=%b data=%0d want 1/7", fwd_hit, fwd_data);
    else n_pass++;
    cpu_raddr = 32'd102;
    #1;
    n_checks++;
    if ({fwd_hit, fwd_data} !== {1'b1, 32'd7})
      $display("FAIL fwd_same_word got hit=%b data=%0d want 1/7", fwd_hit, fwd_data);
    else n_pass++;
    cpu_raddr = 32'd200;
    #1;
    n_checks++;
    if ({fwd_hit, fwd_data} !== {1'b0, 32'd0})
      $display("FAIL fwd_miss got hit=%b data=%0d want 0/0", fwd_hit, fwd_data);
    else n_pass++;
    cpu_we = 1'b1; cpu_addr = 32'd300; cpu_wdata = 32'd9; cpu_raddr = 32'd300;
    #1;
    n_checks++;
    if (fwd_hit !== 1'b0)
      $display("FAIL fwd_inflight_store got hit=%b want 0", fwd_hit);
    else n_pass++;
    tick();
    cpu_we = 1'b0;
    n_checks++;
    if ({fwd_hit, fwd_data, count} !== {1'b1, 32'd9, 3'd3})
      $display("FAIL fwd_after_enqueue got hit=%b data=%0d count=%0d want 1/9/3", fwd_hit, fwd_data, count);
    else n_pass++;
    // the entry being dequeued this cycle must still forward
    mem_ready = 1'b1; cpu_raddr = 32'd100;
    #1;
    n_checks++;
    if ({fwd_hit, fwd_data} !== {1'b1, 32'd7})
      $display("FAIL fwd_during_pop got hit=%b data=%0d want 1/7", fwd_hit, fwd_data);
    else n_pass++;
    for (int i = 0; i < 3; i++) tick();
  endtask

  task automatic test_back_to_back();
    mem_ready = 1'b0;
    store(32'h40, 32'hA0);
    store(32'h44, 32'hA1);
    mem_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      cpu_we = 1'b1; cpu_addr = 32'h1000 + 32'(4 * i); cpu_wdata = 32'hB0 + 32'(i);
      @(negedge clk);
      model_eval();
      n_checks++;
      if ({count, mem_addr, mem_wdata} !== {3'd2, e_ha, e_hd})
        $display("FAIL b2b[%0d] got count=%0d head=%h/%h want 2 %h/%h", i, count, mem_addr, mem_wdata, e_ha, e_hd);
      else n_pass++;
      tick();
    end
    cpu_we = 1'b0;
    tick();
    tick();
    n_checks++;
    if (empty !== 1'b1)
      $display("FAIL b2b_drain got empty=%b want 1", empty);
    else n_pass++;
  endtask

  task automatic test_fence();
    bit done;
    mem_ready = 1'b0;
    for (int i = 0; i < 3; i++) store(32'h200 + 32'(4 * i), 32'h300 + 32'(i));
    fence = 1'b1;
    tick();
    done = 0;
    for (int i = 0; i < 30 && !done; i++) begin
      cpu_we = 1'b1; cpu_addr = 32'h500; cpu_wdata = 32'h55;
      mem_ready = i[0];
      @(negedge clk);
      model_eval();
      n_checks++;
      if ({cpu_stall, count} !== {e_stall, e_count})
        $display("FAIL fence_cycle[%0d] got stall=%b count=%0d want %b/%0d", i, cpu_stall, count, e_stall, e_count);
      else n_pass++;
      if (!m_fence) done = 1;
      else tick();
    end
    cpu_we = 1'b0;
    n_checks++;
    if ({done, empty, cpu_stall} !== 3'b110)
      $display("FAIL fence_release got done=%b empty=%b stall=%b want 1/1/0", done, empty, cpu_stall);
    else n_pass++;
    tick();
    @(negedge clk);
    n_checks++;
    if ({cpu_stall, empty} !== 2'b01)
      $display("FAIL fence_when_empty got stall=%b empty=%b want 0/1", cpu_stall, empty);
    else n_pass++;
    tick();
    fence = 1'b0;
  endtask

  task automatic test_reset_mid_drain();
    mem_ready = 1'b0;
    for (int i = 0; i < 3; i++) store(32'h600 + 32'(4 * i), 32'(i));
    fence = 1'b1;
    tick();
    n_checks++;
    if ({mem_valid, count, cpu_stall} !== {1'b1, 3'd3, 1'b1})
      $display("FAIL pre_reset got valid=%b count=%0d stall=%b want 1/3/1", mem_valid, count, cpu_stall);
    else n_pass++;
    #2 reset_n = 1'b0;
    #1;
    n_checks++;
    if ({mem_valid, count, cpu_stall} !== {1'b0, 3'd0, 1'b0})
      $display("FAIL async_reset got valid=%b count=%0d stall=%b want 0/0/0", mem_valid, count, cpu_stall);
    else n_pass++;
    mq_a.delete();
    mq_d.delete();
    m_fence = 0;
    fence = 1'b0;
    #1 reset_n = 1'b1;
    tick();
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      cpu_we    = 1'($urandom_range(0, 1));
      cpu_addr  = 32'h8000 + 32'($urandom_range(0, 5) * 4);
      cpu_wdata = $urandom;
      cpu_raddr = 32'h8000 + 32'($urandom_range(0, 23));
      mem_ready = ($urandom_range(0, 2) != 0);
      fence     = ($urandom_range(0, 9) == 0);
      @(negedge clk);
      model_eval();
      n_checks++;
      if ({count, empty, mem_valid, cpu_stall, fwd_hit, fwd_data} !==
          {e_count, e_empty, e_valid, e_stall, e_hit, e_fwd})
        $display("FAIL rand[%0d] got cnt=%0d emp=%b val=%b stl=%b hit=%b fwd=%h want %0d/%b/%b/%b/%b/%h",
                 i, count, empty, mem_valid, cpu_stall, fwd_hit, fwd_data,
                 e_count, e_empty, e_valid, e_stall, e_hit, e_fwd);
      else n_pass++;
      if (e_valid) begin
        n_checks++;
        if ({mem_addr, mem_wdata} !== {e_ha, e_hd})
          $display("FAIL rand_head[%0d] got %h/%h want %h/%h", i, mem_addr, mem_wdata, e_ha, e_hd);
        else n_pass++;
      end
      tick();
    end
    cpu_we = 1'b0;
    fence  = 1'b0;
  endtask

  initial begin
    test_reset();
    test_basic_store();
    test_fill_stall();
    test_forwarding();
    test_back_to_back();
    test_fence();
    test_reset_mid_drain();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
